i2c_master_arbiter: RTL and testbench
=====================================

Name: i2c_master_arbiter

Overview:
- Shares one I2CMASTER byte-command interface between two transaction requesters (the MPU6050 register sequencer and a second configuration/sensor sequencer).
- Grants whole transactions round-robin, muxes commands to the master and routes status back to the owner only.
- Enforces a drain-to-STOP and a guard interval between owners; an optional watchdog recovers a hung owner.
- Sits between requesters and I2CMASTER; all sequencing is qualified by the shared TIC strobe.

Parameters:
- GUARD_TICS, 4, TIC cycles of idle bus between releasing one owner and granting the next (1..255).
- TIMEOUT_TICS, 2048, watchdog limit in TIC cycles without owner progress (used only with the watchdog macro; 2..65535).

Ports:
- MCLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- TIC  in  1  one-MCLK enable strobe; all FSM/counter updates occur only on cycles with TIC=1
- REQ  in  2  per-requester bus request, level, held for the whole transaction
- GNT  out  2  one-hot grant, registered
- REQ_SRST  in  2  per-requester soft reset of master
- REQ_DIN  in  16  byte for requester i at bits [8i+7:8i]
- REQ_RD  in  2  per-requester read command
- REQ_WE  in  2  per-requester write command
- REQ_QUEUED  out  2  M_QUEUED routed to owner, 0 to other
- REQ_NACK  out  2  M_NACK routed to owner
- REQ_DATA_VALID  out  2  M_DATA_VALID routed to owner
- REQ_STOP  out  2  M_STOP routed to owner
- REQ_DOUT  out  8  M_DOUT broadcast (qualified by REQ_DATA_VALID)
- M_SRST  out  1  to master SRST
- M_DIN  out  8  to master DIN
- M_RD  out  1  to master RD
- M_WE  out  1  to master WE
- M_QUEUED, M_NACK, M_DATA_VALID, M_STOP  in  1 each  from master
- M_DOUT  in  8  from master
- ERR  out  1  sticky watchdog-abort flag, cleared on next grant

Behaviour:
- Reset (async, nRST=0): state IDLE, GNT=0, M_SRST/M_RD/M_WE=0, M_DIN=0, all REQ_* outputs 0, ERR=0, rr pointer=0 (requester 0 has priority first), counters 0.
- Command mux is combinational from registered GNT: M_DIN/M_RD/M_WE/M_SRST = owner's inputs; all 0 when GNT=0. Non-owner commands are ignored entirely. Status routing likewise combinational; zero added latency.
- FSM, evaluated on TIC cycles:
  - IDLE: if any REQ, grant per rr pointer (pointer indicates preferred requester; if only one requests, grant it) -> OWN. GNT asserts after that edge; owner may issue first command on the following TIC. Pointer := other requester.
  - OWN: stop_seen set on M_STOP, cleared on M_RD|M_WE, initialised 1 at grant. On owner REQ=0: if stop_seen -> GUARD else DRAIN. GNT stays asserted until leaving OWN/DRAIN.
  - DRAIN: commands still muxed; on M_STOP -> GUARD.
  - GUARD: GNT=0, count GUARD_TICS TICs -> IDLE.
- Simultaneous REQ at IDLE: rr pointer decides; repeated contention alternates 0,1,0,1.
- REQ re-raised by owner during DRAIN/GUARD: no extension; treated as new request in IDLE.
- Owner REQ_SRST passes through; it does not end ownership.
- REQ dropped and re-raised within the same TIC-free window is not visible; only TIC-sampled levels count.

Optional Feature:
- Macro I2C_ARB_WATCHDOG_EN.
- With it: 16-bit counter cleared on grant and on any M_QUEUED/M_DATA_VALID/M_STOP, incremented each TIC in OWN/DRAIN. At TIMEOUT_TICS: drive M_SRST=1 for exactly one TIC period (one TIC-to-TIC interval), set ERR, drop GNT, -> GUARD.
- Without it: no counter, ERR tied 0, OWN/DRAIN wait indefinitely.

Decomposition:
- Package i2c_arb_pkg: state encoding (IDLE, OWN, DRAIN, GUARD), requester-count constant 2, requester index width.
- No sub-module. The watchdog counter stays inline under the macro.

Test Plan:
- Only REQ[0] raised: GNT=2'b01 after one TIC. REQ_WE[0] with REQ_DIN[7:0]=8'h6B gives M_WE=1, M_DIN=8'h6B the same cycle. Requester 1 commands do not reach master.
- REQ=2'b11 held continuously, owners drop after STOP: grants alternate 01,00(GUARD 4 TICs),10,00,01. No overlap.
- Owner drops REQ after WE, before M_STOP: GNT stays 01 in DRAIN. M_STOP pulse, then GNT=00 for exactly 4 TICs, then pending requester granted.
- Non-owner: REQ_QUEUED/REQ_NACK/REQ_DATA_VALID stay 0 for the non-owner while master pulses them. REQ_DOUT equals M_DOUT.
- nRST pulsed low mid-OWN: GNT, M_RD, M_WE, M_DIN immediately 0 (async). After release, requester 0 is granted first.
- With I2C_ARB_WATCHDOG_EN, TIMEOUT_TICS=16, owner silent, master silent: after 16 TICs M_SRST=1 for one TIC, ERR=1, GNT=00. The next grant clears ERR.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types for the two-requester I2C master arbiter.
// State encoding and requester sizing constants.
package i2c_arb_pkg;

    localparam int NUM_REQ   = 2;
    localparam int REQ_IDX_W = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2,
        GUARD = 2'd3
    } arb_state_t;

endpackage

// File: rtl/i2c_master_arbiter.sv
// Round-robin owner arbitration of one I2C master byte-command port.
// Optional watchdog recovery of a hung owner under I2C_ARB_WATCHDOG_EN.
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int GUARD_TICS   = 4,
    parameter int TIMEOUT_TICS = 2048
) (
    input  logic                 MCLK,
    input  logic                 nRST,
    input  logic                 TIC,
    input  logic [NUM_REQ-1:0]   REQ,
    output logic [NUM_REQ-1:0]   GNT,
    input  logic [NUM_REQ-1:0]   REQ_SRST,
    input  logic [NUM_REQ*8-1:0] REQ_DIN,
    input  logic [NUM_REQ-1:0]   REQ_RD,
    input  logic [NUM_REQ-1:0]   REQ_WE,
    output logic [NUM_REQ-1:0]   REQ_QUEUED,
    output logic [NUM_REQ-1:0]   REQ_NACK,
    output logic [NUM_REQ-1:0]   REQ_DATA_VALID,
    output logic [NUM_REQ-1:0]   REQ_STOP,
    output logic [7:0]           REQ_DOUT,
    output logic                 M_SRST,
    output logic [7:0]           M_DIN,
    output logic                 M_RD,
    output logic                 M_WE,
    input  logic                 M_QUEUED,
    input  logic                 M_NACK,
    input  logic                 M_DATA_VALID,
    input  logic                 M_STOP,
    input  logic [7:0]           M_DOUT,
    output logic                 ERR
);

    arb_state_t           state;
    logic [NUM_REQ-1:0]   gnt;
    logic [REQ_IDX_W-1:0] ptr;
    logic                 stop_seen;
    logic [7:0]           guard_cnt;
    logic                 owner_srst;
    logic                 wd_srst;

    logic [REQ_IDX_W-1:0] pick;
    logic [NUM_REQ-1:0]   pick_gnt;
    logic                 any_req;
    logic                 own_req;
    logic                 cmd;
    logic                 stop_nxt;
    logic                 guard_last;
    logic                 arb_now;

    assign GNT      = gnt;
    assign any_req  = |REQ;
    assign own_req  = |(REQ & gnt);
    assign pick     = (REQ == 2'b11) ? ptr : REQ[1];
    assign pick_gnt = pick ? 2'b10 : 2'b01;
    assign cmd      = M_RD | M_WE;
    assign stop_nxt = M_STOP | (stop_seen & ~cmd);

    assign guard_last = (guard_cnt == 8'(GUARD_TICS - 1));
    // The last guard TIC arbitrates directly so the bus idles exactly GUARD_TICS.
    assign arb_now = (state == IDLE) || (state == GUARD && guard_last);

    always_comb begin
        M_DIN      = '0;
        M_RD       = 1'b0;
        M_WE       = 1'b0;
        owner_srst = 1'b0;
        unique case (1'b1)
            gnt[0]: begin
                M_DIN      = REQ_DIN[7:0];
                M_RD       = REQ_RD[0];
                M_WE       = REQ_WE[0];
                owner_srst = REQ_SRST[0];
            end
            gnt[1]: begin
                M_DIN      = REQ_DIN[15:8];
                M_RD       = REQ_RD[1];
                M_WE       = REQ_WE[1];
                owner_srst = REQ_SRST[1];
            end
            default: ;
        endcase
    end

    assign M_SRST         = owner_srst | wd_srst;
    assign REQ_QUEUED     = gnt & {NUM_REQ{M_QUEUED}};
    assign REQ_NACK       = gnt & {NUM_REQ{M_NACK}};
    assign REQ_DATA_VALID = gnt & {NUM_REQ{M_DATA_VALID}};
    assign REQ_STOP       = gnt & {NUM_REQ{M_STOP}};
    assign REQ_DOUT       = M_DOUT;

`ifdef I2C_ARB_WATCHDOG_EN
    logic [15:0] wd_cnt;
    logic        err;
    logic        progress;

    assign ERR      = err;
    assign progress = M_QUEUED | M_DATA_VALID | M_STOP;
`else
    logic [15:0] unused_timeout;

    assign unused_timeout = 16'(TIMEOUT_TICS);
    assign wd_srst        = 1'b0;
    assign ERR            = 1'b0;
`endif

    always_ff @(posedge MCLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            gnt       <= '0;
            ptr       <= '0;
            stop_seen <= 1'b0;
            guard_cnt <= '0;
`ifdef I2C_ARB_WATCHDOG_EN
            wd_cnt    <= '0;
            wd_srst   <= 1'b0;
            err       <= 1'b0;
`endif
        end else if (TIC) begin
            case (state)
                OWN: begin
                    stop_seen <= stop_nxt;
                    if (!own_req) begin
                        if (stop_nxt) begin
                            state     <= GUARD;
                            gnt       <= '0;
                            guard_cnt <= '0;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (M_STOP) begin
                        state     <= GUARD;
                        gnt       <= '0;
                        guard_cnt <= '0;
                    end
                end
                GUARD: begin
                    if (guard_last) state <= IDLE;
                    else guard_cnt <= guard_cnt + 8'd1;
                end
                default: ;
            endcase
`ifdef I2C_ARB_WATCHDOG_EN
            wd_srst <= 1'b0;
            if (state == OWN || state == DRAIN) begin
                if (progress) begin
                    wd_cnt <= '0;
                end else if (wd_cnt == 16'(TIMEOUT_TICS - 1)) begin
                    wd_srst   <= 1'b1;
                    err       <= 1'b1;
                    gnt       <= '0;
                    state     <= GUARD;
                    guard_cnt <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 16'd1;
                end
            end
`endif
            if (arb_now && any_req) begin
                state     <= OWN;
                gnt       <= pick_gnt;
                ptr       <= ~pick;
                stop_seen <= 1'b1;
`ifdef I2C_ARB_WATCHDOG_EN
                wd_cnt    <= '0;
                err       <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed vector bench for i2c_master_arbiter.
// Watchdog sequence runs only when I2C_ARB_WATCHDOG_EN is defined.
module tb_i2c_master_arbiter;

    logic        MCLK = 1'b0;
    logic        nRST = 1'b0;
    logic        TIC = 1'b0;
    logic [1:0]  REQ = '0;
    logic [1:0]  GNT;
    logic [1:0]  REQ_SRST = '0;
    logic [15:0] REQ_DIN = '0;
    logic [1:0]  REQ_RD = '0;
    logic [1:0]  REQ_WE = '0;
    logic [1:0]  REQ_QUEUED, REQ_NACK, REQ_DATA_VALID, REQ_STOP;
    logic [7:0]  REQ_DOUT;
    logic        M_SRST;
    logic [7:0]  M_DIN;
    logic        M_RD, M_WE;
    logic        M_QUEUED = 1'b0;
    logic        M_NACK = 1'b0;
    logic        M_DATA_VALID = 1'b0;
    logic        M_STOP = 1'b0;
    logic [7:0]  M_DOUT = '0;
    logic        ERR;

    int n_cmp = 0;
    int n_err = 0;

    always #5 MCLK = ~MCLK;

    i2c_master_arbiter #(.GUARD_TICS(4), .TIMEOUT_TICS(16)) dut (
        .MCLK(MCLK), .nRST(nRST), .TIC(TIC), .REQ(REQ), .GNT(GNT),
        .REQ_SRST(REQ_SRST), .REQ_DIN(REQ_DIN), .REQ_RD(REQ_RD),
        .REQ_WE(REQ_WE), .REQ_QUEUED(REQ_QUEUED), .REQ_NACK(REQ_NACK),
        .REQ_DATA_VALID(REQ_DATA_VALID), .REQ_STOP(REQ_STOP),
        .REQ_DOUT(REQ_DOUT), .M_SRST(M_SRST), .M_DIN(M_DIN), .M_RD(M_RD),
        .M_WE(M_WE), .M_QUEUED(M_QUEUED), .M_NACK(M_NACK),
        .M_DATA_VALID(M_DATA_VALID), .M_STOP(M_STOP), .M_DOUT(M_DOUT),
        .ERR(ERR)
    );

    typedef struct {
        logic [1:0]  req, we, rd, srst;
        logic [15:0] din;
        logic        mq, mn, mdv, mstop;
        logic [7:0]  mdout;
        logic [1:0]  e_gnt;
        logic        e_we, e_rd, e_srst;
        logic [7:0]  e_din;
        logic [1:0]  e_q, e_n, e_dv, e_stop;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_tic();
        @(negedge MCLK) TIC = 1'b1;
        @(negedge MCLK) TIC = 1'b0;
    endtask

    task automatic clr_inputs();
        REQ = '0; REQ_SRST = '0; REQ_DIN = '0; REQ_RD = '0; REQ_WE = '0;
        M_QUEUED = 0; M_NACK = 0; M_DATA_VALID = 0; M_STOP = 0; M_DOUT = '0;
    endtask

    task automatic do_reset();
        clr_inputs();
        TIC = 1'b0;
        @(negedge MCLK) nRST = 1'b0;
        repeat (2) @(negedge MCLK);
        nRST = 1'b1;
        @(negedge MCLK);
    endtask

    // Ticks until a grant appears; returns number of TICs seen with GNT=0.
    task automatic wait_grant(output int zeros);
        zeros = 0;
        while (GNT == 2'b00 && zeros < 20) begin
            do_tic();
            zeros++;
        end
    endtask

    initial begin
        int zeros;
        vt[0]  = '{2'b01, 2'b00, 2'b00, 2'b00, 16'h0000, 0, 0, 0, 0, 8'h00,
                   2'b01, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[1]  = '{2'b11, 2'b10, 2'b00, 2'b00, 16'hAA00, 0, 0, 0, 0, 8'h00,
                   2'b01, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[2]  = '{2'b11, 2'b11, 2'b00, 2'b00, 16'hAA6B, 0, 0, 0, 0, 8'h00,
                   2'b01, 1, 0, 0, 8'h6B, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[3]  = '{2'b11, 2'b00, 2'b10, 2'b00, 16'h0000, 1, 0, 0, 0, 8'h00,
                   2'b01, 0, 0, 0, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00};
        vt[4]  = '{2'b11, 2'b00, 2'b00, 2'b00, 16'h0000, 0, 1, 1, 0, 8'h5A,
                   2'b01, 0, 0, 0, 8'h00, 2'b00, 2'b01, 2'b01, 2'b00};
        vt[5]  = '{2'b11, 2'b00, 2'b00, 2'b11, 16'h0000, 0, 0, 0, 0, 8'h00,
                   2'b01, 0, 0, 1, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[6]  = '{2'b10, 2'b00, 2'b00, 2'b00, 16'h0000, 0, 0, 0, 0, 8'h00,
                   2'b01, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[7]  = '{2'b10, 2'b00, 2'b00, 2'b00, 16'h0000, 0, 0, 0, 1, 8'h00,
                   2'b00, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b01};
        vt[8]  = '{2'b10, 2'b00, 2'b00, 2'b00, 16'h0000, 1, 1, 1, 1, 8'hC5,
                   2'b00, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[9]  = '{2'b10, 2'b00, 2'b00, 2'b00, 16'h0000, 0, 0, 0, 0, 8'h00,
                   2'b00, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[10] = '{2'b10, 2'b00, 2'b00, 2'b00, 16'h0000, 0, 0, 0, 0, 8'h00,
                   2'b00, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[11] = '{2'b10, 2'b00, 2'b00, 2'b00, 16'h0000, 0, 0, 0, 0, 8'h00,
                   2'b10, 0, 0, 0, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00};
        vt[12] = '{2'b10, 2'b11, 2'b00, 2'b00, 16'h1234, 1, 0, 0, 0, 8'h00,
                   2'b10, 1, 0, 0, 8'h12, 2'b10, 2'b00, 2'b00, 2'b00};

        do_reset();
        chk("reset_gnt", 16'(GNT), 16'h0);
        chk("reset_err", 16'(ERR), 16'h0);
        chk("reset_mwe", 16'({M_SRST, M_RD, M_WE}), 16'h0);

        for (int i = 0; i < 13; i++) begin
            REQ = vt[i].req; REQ_WE = vt[i].we; REQ_RD = vt[i].rd;
            REQ_SRST = vt[i].srst; REQ_DIN = vt[i].din;
            M_QUEUED = vt[i].mq; M_NACK = vt[i].mn;
            M_DATA_VALID = vt[i].mdv; M_STOP = vt[i].mstop;
            M_DOUT = vt[i].mdout;
            #1;
            chk($sformatf("v%0d_mwe", i), 16'(M_WE), 16'(vt[i].e_we));
            chk($sformatf("v%0d_mrd", i), 16'(M_RD), 16'(vt[i].e_rd));
            chk($sformatf("v%0d_msrst", i), 16'(M_SRST), 16'(vt[i].e_srst));
            chk($sformatf("v%0d_mdin", i), 16'(M_DIN), 16'(vt[i].e_din));
            chk($sformatf("v%0d_queued", i), 16'(REQ_QUEUED), 16'(vt[i].e_q));
            chk($sformatf("v%0d_nack", i), 16'(REQ_NACK), 16'(vt[i].e_n));
            chk($sformatf("v%0d_dv", i), 16'(REQ_DATA_VALID), 16'(vt[i].e_dv));
            chk($sformatf("v%0d_stop", i), 16'(REQ_STOP), 16'(vt[i].e_stop));
            chk($sformatf("v%0d_dout", i), 16'(REQ_DOUT), 16'(vt[i].mdout));
            do_tic();
            chk($sformatf("v%0d_gnt", i), 16'(GNT), 16'(vt[i].e_gnt));
            chk($sformatf("v%0d_err", i), 16'(ERR), 16'h0);
        end

        // Continuous contention: owners release after STOP, grants alternate.
        do_reset();
        REQ = 2'b11;
        for (int r = 0; r < 4; r++) begin
            wait_grant(zeros);
            chk($sformatf("alt%0d_gnt", r), 16'(GNT),
                (r % 2 == 1) ? 16'h2 : 16'h1);
            chk($sformatf("alt%0d_idle_tics", r), 16'(zeros),
                (r == 0) ? 16'd1 : 16'd4);
            M_STOP = 1'b1;
            do_tic();
            M_STOP = 1'b0;
            chk($sformatf("alt%0d_overlap", r), 16'(GNT == 2'b11), 16'h0);
            REQ = 2'b11 & ~GNT;
            do_tic();
            chk($sformatf("alt%0d_release", r), 16'(GNT), 16'h0);
            REQ = 2'b11;
        end

        // Asynchronous reset in the middle of ownership.
        do_reset();
        REQ = 2'b01;
        do_tic();
        REQ_WE = 2'b01; REQ_RD = 2'b01; REQ_DIN = 16'h00C3;
        #1;
        chk("arst_pre_mwe", 16'({M_WE, M_DIN}), 16'h1C3);
        #2 nRST = 1'b0;
        #1;
        chk("arst_gnt", 16'(GNT), 16'h0);
        chk("arst_cmd", 16'({M_RD, M_WE, M_DIN}), 16'h0);
        @(negedge MCLK) nRST = 1'b1;
        REQ_WE = '0; REQ_RD = '0; REQ_DIN = '0;
        REQ = 2'b11;
        do_tic();
        chk("arst_first_gnt", 16'(GNT), 16'h1);

`ifdef I2C_ARB_WATCHDOG_EN
        do_reset();
        REQ = 2'b01;
        do_tic();
        chk("wd_gnt", 16'(GNT), 16'h1);
        repeat (15) do_tic();
        chk("wd_pre_gnt", 16'(GNT), 16'h1);
        chk("wd_pre_srst", 16'(M_SRST), 16'h0);
        do_tic();
        chk("wd_srst", 16'(M_SRST), 16'h1);
        chk("wd_err", 16'(ERR), 16'h1);
        chk("wd_gnt_drop", 16'(GNT), 16'h0);
        do_tic();
        chk("wd_srst_end", 16'(M_SRST), 16'h0);
        chk("wd_err_sticky", 16'(ERR), 16'h1);
        wait_grant(zeros);
        chk("wd_regrant", 16'(GNT), 16'h1);
        chk("wd_regrant_tics", 16'(zeros), 16'd3);
        chk("wd_err_clr", 16'(ERR), 16'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
